// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master sequencer for the iicmb_m_wb core: expands single-byte
// I2C read/write requests into the CSR/DPR/CMDR register program and
// reports completion status back to the requester.
module i2cmb_wb_sequencer #(
  parameter int unsigned NUM_I2C_BUSSES = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned BUS_W = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_rw_i,
  input  logic [BUS_W-1:0] req_bus_i,
  input  logic [6:0]       req_addr_i,
  input  logic [7:0]       req_data_i,
  output logic             rsp_valid_o,
  output logic [7:0]       rsp_data_o,
  output logic [1:0]       rsp_status_o,
  output logic             cyc_o,
  output logic             stb_o,
  output logic             we_o,
  output logic [1:0]       adr_o,
  output logic [7:0]       dat_o,
  input  logic [7:0]       dat_i,
  input  logic             ack_i,
  input  logic             irq_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_NAK = 2'b01;
  localparam logic [1:0] ST_AL  = 2'b10;
  localparam logic [1:0] ST_ERR = 2'b11;

  typedef enum logic [3:0] {
    S_ENABLE, S_IDLE, S_SETBUS_DPR, S_SETBUS_CMD, S_START_CMD, S_ADDR_DPR,
    S_ADDR_CMD, S_DATA_DPR, S_DATA_CMD, S_STOP_CMD, S_WAIT, S_RD_CMDR,
    S_RD_DPR, S_RESP
  } state_t;

  typedef enum logic [2:0] {P_SETBUS, P_START, P_ADDR, P_DATA, P_STOP} phase_t;

  state_t             state;
  phase_t             phase;
  logic               rw_q;
  logic [BUS_W-1:0]   bus_q;
  logic [6:0]         addr_q;
  logic [7:0]         data_q;
  logic [BUS_W-1:0]   last_bus;
  logic               bus_valid;
  logic               nak_q;
  logic [CNT_W-1:0]   tmo_cnt;

  logic               acc_en;
  logic               acc_we;
  logic               acc_cmd;
  logic [1:0]         acc_adr;
  logic [7:0]         acc_dat;
  phase_t             acc_phase;

  logic               nak_ok;
  logic               dec_abort;
  logic               dec_nak;
  logic [1:0]         dec_status;

  // Register access each state performs; acc_cmd marks CMDR writes that are followed by WAIT.
  always_comb begin
    acc_en    = 1'b1;
    acc_we    = 1'b1;
    acc_cmd   = 1'b0;
    acc_adr   = REG_CMDR;
    acc_dat   = '0;
    acc_phase = P_START;
    case (state)
      S_ENABLE:     begin acc_adr = REG_CSR; acc_dat = 8'hC0; end
      S_SETBUS_DPR: begin acc_adr = REG_DPR; acc_dat = 8'(bus_q); end
      S_SETBUS_CMD: begin acc_cmd = 1'b1; acc_dat = 8'h06; acc_phase = P_SETBUS; end
      S_START_CMD:  begin acc_cmd = 1'b1; acc_dat = 8'h04; acc_phase = P_START; end
      S_ADDR_DPR:   begin acc_adr = REG_DPR; acc_dat = {addr_q, rw_q}; end
      S_ADDR_CMD:   begin acc_cmd = 1'b1; acc_dat = 8'h01; acc_phase = P_ADDR; end
      S_DATA_DPR:   begin acc_adr = REG_DPR; acc_dat = data_q; end
      S_DATA_CMD:   begin acc_cmd = 1'b1; acc_dat = rw_q ? 8'h03 : 8'h01; acc_phase = P_DATA; end
      S_STOP_CMD:   begin acc_cmd = 1'b1; acc_dat = 8'h05; acc_phase = P_STOP; end
      S_RD_CMDR:    acc_we = 1'b0;
      S_RD_DPR:     begin acc_we = 1'b0; acc_adr = REG_DPR; end
      default:      acc_en = 1'b0;
    endcase
  end

  // CMDR status decode with ERR > AL > NAK > DON priority; NAK is only recoverable on ADDR/write DATA.
  always_comb begin
    nak_ok     = (phase == P_ADDR) || ((phase == P_DATA) && !rw_q);
    dec_abort  = 1'b0;
    dec_nak    = 1'b0;
    dec_status = ST_ERR;
    if (dat_i[4]) begin
      dec_abort = 1'b1;
    end else if (dat_i[5]) begin
      dec_abort  = 1'b1;
      dec_status = ST_AL;
    end else if (dat_i[6]) begin
      if (nak_ok) dec_nak = 1'b1;
      else        dec_abort = 1'b1;
    end else if (!dat_i[7]) begin
      dec_abort = 1'b1;
    end
  end

  // Sequencer FSM: Wishbone cycle handling, irq wait/timeout and response generation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= S_ENABLE;
      phase        <= P_START;
      rw_q         <= 1'b0;
      bus_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      last_bus     <= '0;
      bus_valid    <= 1'b0;
      nak_q        <= 1'b0;
      tmo_cnt      <= '0;
      req_ready_o  <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      rsp_status_o <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (acc_en) begin
        if (!cyc_o) begin
          cyc_o <= 1'b1;
          stb_o <= 1'b1;
          we_o  <= acc_we;
          adr_o <= acc_adr;
          dat_o <= acc_dat;
        end else if (ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          adr_o <= '0;
          dat_o <= '0;
          if (acc_cmd) begin
            phase   <= acc_phase;
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end else begin
            case (state)
              S_ENABLE:     begin state <= S_IDLE; req_ready_o <= 1'b1; end
              S_SETBUS_DPR: state <= S_SETBUS_CMD;
              S_ADDR_DPR:   state <= S_ADDR_CMD;
              S_DATA_DPR:   state <= S_DATA_CMD;
              S_RD_DPR: begin
                rsp_data_o   <= dat_i;
                rsp_status_o <= ST_OK;
                rsp_valid_o  <= 1'b1;
                state        <= S_RESP;
              end
              S_RD_CMDR: begin
                if (dec_abort) begin
                  rsp_status_o <= dec_status;
                  bus_valid    <= 1'b0;
                  rsp_valid_o  <= 1'b1;
                  state        <= S_RESP;
                end else if (dec_nak) begin
                  nak_q <= 1'b1;
                  state <= S_STOP_CMD;
                end else begin
                  case (phase)
                    P_SETBUS: begin
                      last_bus  <= bus_q;
                      bus_valid <= 1'b1;
                      state     <= S_START_CMD;
                    end
                    P_START: state <= S_ADDR_DPR;
                    P_ADDR:  state <= rw_q ? S_DATA_CMD : S_DATA_DPR;
                    P_DATA:  state <= S_STOP_CMD;
                    default: begin
                      if (!nak_q && rw_q) begin
                        state <= S_RD_DPR;
                      end else begin
                        rsp_status_o <= nak_q ? ST_NAK : ST_OK;
                        rsp_valid_o  <= 1'b1;
                        state        <= S_RESP;
                      end
                    end
                  endcase
                end
              end
              default: state <= state;
            endcase
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid_i) begin
              req_ready_o <= 1'b0;
              rw_q        <= req_rw_i;
              bus_q       <= req_bus_i;
              addr_q      <= req_addr_i;
              data_q      <= req_data_i;
              nak_q       <= 1'b0;
              state       <= (!bus_valid || (req_bus_i != last_bus)) ? S_SETBUS_DPR : S_START_CMD;
            end
          end
          S_WAIT: begin
            if (irq_i) begin
              state <= S_RD_CMDR;
            end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              rsp_status_o <= ST_ERR;
              bus_valid    <= 1'b0;
              rsp_valid_o  <= 1'b1;
              state        <= S_RESP;
            end else begin
              tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
          end
          S_RESP: begin
            req_ready_o <= 1'b1;
            state       <= S_IDLE;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Directed bench for i2cmb_wb_sequencer: a small iicmb register responder
// logs every Wishbone access, and the main sequence compares the logged
// register program and responses against hand-written expectations.
module tb_i2cmb_wb_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       req_rw_i = 1'b0;
  logic [1:0] req_bus_i = '0;
  logic [6:0] req_addr_i = '0;
  logic [7:0] req_data_i = '0;
  logic       rsp_valid_o;
  logic [7:0] rsp_data_o;
  logic [1:0] rsp_status_o;
  logic       cyc_o, stb_o, we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack_i = 1'b0;
  logic       irq_i = 1'b0;

  int checks = 0;
  int errors = 0;

  // responder controls and state
  logic        hold_ack = 1'b0;
  logic        irq_en = 1'b1;
  logic [7:0]  nak_cmd = 8'hFF;
  logic [7:0]  dpr_rd = 8'h00;
  logic [7:0]  last_cmd = 8'h00;
  int          irq_dly = 0;
  int          cyc_cnt = 0;
  int          last_ack_cnt = 0;
  int          rsp_cnt = 0;
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];

  i2cmb_wb_sequencer #(
    .NUM_I2C_BUSSES(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rw_i(req_rw_i),
    .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_status_o(rsp_status_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  always #5 clk = ~clk;

  initial forever @(posedge clk) cyc_cnt++;

  // Register responder: acks one cycle after strobe, raises irq a few cycles
  // after each CMDR write, clears irq on CMDR read.
  initial forever begin
    @(negedge clk);
    if (irq_dly > 0) begin
      irq_dly--;
      if (irq_dly == 0) irq_i = 1'b1;
    end
    if (ack_i) begin
      ack_i = 1'b0;
    end else if (cyc_o && stb_o && !hold_ack) begin
      ack_i = 1'b1;
      log_q.push_back({we_o, adr_o, dat_o});
      dat_i = 8'h00;
      if (we_o && adr_o == 2'd2) begin
        last_cmd     = dat_o;
        last_ack_cnt = cyc_cnt + 1;
        if (irq_en) irq_dly = 3;
      end else if (!we_o && adr_o == 2'd2) begin
        dat_i = (last_cmd == nak_cmd) ? 8'hC0 : 8'h80;
        irq_i = 1'b0;
      end else if (!we_o && adr_o == 2'd1) begin
        dat_i = dpr_rd;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] wr(input logic [1:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [10:0] rd(input logic [1:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  task automatic push_cmd(input logic [7:0] c);
    exp_q.push_back(wr(2'd2, c));
    exp_q.push_back(rd(2'd2));
  endtask

  task automatic push_setbus(input logic [7:0] b);
    exp_q.push_back(wr(2'd1, b));
    push_cmd(8'h06);
  endtask

  task automatic push_write(input logic [6:0] a, input logic [7:0] d);
    push_cmd(8'h04);
    exp_q.push_back(wr(2'd1, {a, 1'b0}));
    push_cmd(8'h01);
    exp_q.push_back(wr(2'd1, d));
    push_cmd(8'h01);
    push_cmd(8'h05);
  endtask

  task automatic push_read(input logic [6:0] a);
    push_cmd(8'h04);
    exp_q.push_back(wr(2'd1, {a, 1'b1}));
    push_cmd(8'h01);
    push_cmd(8'h03);
    push_cmd(8'h05);
    exp_q.push_back(rd(2'd1));
  endtask

  task automatic check_log(input string tag);
    chk({tag, " len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) chk($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic do_req(input logic rw, input logic [1:0] bus, input logic [6:0] addr,
                        input logic [7:0] data);
    int n = 0;
    while (!req_ready_o && n < 1000) begin @(negedge clk); n++; end
    chk("req_ready", req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_rw_i    = rw;
    req_bus_i   = bus;
    req_addr_i  = addr;
    req_data_i  = data;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("req_taken", req_ready_o, 1'b0);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] st, input logic [7:0] data);
    int n = 0;
    while (!rsp_valid_o && n < 1000) begin @(negedge clk); n++; end
    chk({tag, " rsp_seen"}, rsp_valid_o, 1'b1);
    rsp_cnt = cyc_cnt;
    chk({tag, " status"}, rsp_status_o, st);
    chk({tag, " data"}, rsp_data_o, data);
    @(negedge clk);
    chk({tag, " rsp_pulse"}, rsp_valid_o, 1'b0);
  endtask

  initial begin
    int n;
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst cyc", cyc_o, 1'b0);
    chk("rst stb", stb_o, 1'b0);
    chk("rst ready", req_ready_o, 1'b0);
    chk("rst rsp_valid", rsp_valid_o, 1'b0);
    chk("rst status", rsp_status_o, 2'b00);
    chk("rst data", rsp_data_o, 8'h00);
    rst_ni = 1'b1;

    // first write: enable, set bus 0, full write program
    do_req(1'b0, 2'd0, 7'h22, 8'hA5);
    wait_rsp("wr1", 2'b00, 8'h00);
    exp_q.push_back(wr(2'd0, 8'hC0));
    push_setbus(8'h00);
    push_write(7'h22, 8'hA5);
    check_log("wr1 log");

    // same bus: no set-bus accesses
    do_req(1'b0, 2'd0, 7'h22, 8'h5A);
    wait_rsp("wr2", 2'b00, 8'h00);
    push_write(7'h22, 8'h5A);
    check_log("wr2 log");

    // read on same bus
    dpr_rd = 8'h3C;
    do_req(1'b1, 2'd0, 7'h22, 8'h00);
    wait_rsp("rd1", 2'b00, 8'h3C);
    push_read(7'h22);
    check_log("rd1 log");

    // read on a different bus re-selects the bus
    dpr_rd = 8'h9E;
    do_req(1'b1, 2'd2, 7'h22, 8'h00);
    wait_rsp("rd2", 2'b00, 8'h9E);
    push_setbus(8'h02);
    push_read(7'h22);
    check_log("rd2 log");

    // address NAK: stop issued, no data phase, read data held
    nak_cmd = 8'h01;
    do_req(1'b0, 2'd2, 7'h10, 8'h77);
    wait_rsp("nak", 2'b01, 8'h9E);
    nak_cmd = 8'hFF;
    push_cmd(8'h04);
    exp_q.push_back(wr(2'd1, 8'h20));
    push_cmd(8'h01);
    push_cmd(8'h05);
    check_log("nak log");

    // timeout with irq never asserted
    irq_en = 1'b0;
    do_req(1'b0, 2'd2, 7'h22, 8'h11);
    wait_rsp("tmo", 2'b11, 8'h9E);
    chk("tmo latency", rsp_cnt - last_ack_cnt, 100);
    exp_q.push_back(wr(2'd2, 8'h04));
    check_log("tmo log");
    irq_en = 1'b1;

    // after timeout the bus is selected again
    do_req(1'b0, 2'd2, 7'h22, 8'h11);
    wait_rsp("post_tmo", 2'b00, 8'h9E);
    push_setbus(8'h02);
    push_write(7'h22, 8'h11);
    check_log("post_tmo log");

    // asynchronous reset during a stalled Wishbone cycle
    hold_ack = 1'b1;
    do_req(1'b0, 2'd2, 7'h22, 8'h33);
    n = 0;
    while (!stb_o && n < 200) begin @(negedge clk); n++; end
    chk("mid stb", stb_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst cyc", cyc_o, 1'b0);
    chk("arst stb", stb_o, 1'b0);
    chk("arst ready", req_ready_o, 1'b0);
    hold_ack = 1'b0;
    irq_i    = 1'b0;
    irq_dly  = 0;
    ack_i    = 1'b0;
    log_q.delete();
    @(negedge clk);
    #2 rst_ni = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin @(negedge clk); n++; end
    chk("arst ready again", req_ready_o, 1'b1);
    exp_q.push_back(wr(2'd0, 8'hC0));
    check_log("arst log");

    // bus selection is forgotten across reset
    do_req(1'b0, 2'd0, 7'h22, 8'hA5);
    wait_rsp("wr3", 2'b00, 8'h00);
    push_setbus(8'h00);
    push_write(7'h22, 8'hA5);
    check_log("wr3 log");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2cmb_wb_sequencer.md
Name: i2cmb_wb_sequencer

Overview:
- Hardware command sequencer that drives the iicmb_m_wb register interface (CSR=0, DPR=1, CMDR=2, FSMR=3) as a Wishbone master.
- Turns single-byte I2C write/read requests into the full register program: enable, set bus, start, address, data, stop.
- Completes each I2C command by waiting on irq, then reading CMDR to check status and clear the interrupt.
- Sits between an upstream requester and the DUT's Wishbone slave port, replacing the software/BFM driver.

Parameters:
- NUM_I2C_BUSSES, 1, number of I2C busses behind the DUT; bus index width BUS_W = max(1, $clog2(NUM_I2C_BUSSES)).
- TIMEOUT_CYCLES, 65535, clk_i cycles allowed between command issue and irq before ERR is reported.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_rw_i  in  1  0=write, 1=read
- req_bus_i  in  BUS_W  target I2C bus
- req_addr_i  in  7  I2C slave address
- req_data_i  in  8  write byte
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_data_o  out  8  read byte, held until next rsp
- rsp_status_o  out  2  00 OK, 01 NAK, 10 arbitration lost, 11 error/timeout
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  2  register address
- dat_o  out  8  write data
- dat_i  in  8  read data
- ack_i  in  1  Wishbone ack
- irq_i  in  1  DUT interrupt

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, FSM=ENABLE, bus_valid=0, timeout counter=0; any in-flight Wishbone cycle is dropped immediately.
- Wishbone access: cyc_o, stb_o, adr_o, dat_o and we_o assert together and hold until the cycle ack_i=1 is sampled. All drop on the next cycle; at least one idle cycle between accesses. Read data is captured on the ack cycle.
- ENABLE: write CSR=0xC0 (enable + interrupt enable), then IDLE. Runs once per reset.
- IDLE: req_ready_o=1; all other states hold it at 0. On handshake, latch rw, bus, addr and data.
- Bus select: if bus_valid=0 or bus != last_bus, write DPR=bus, then CMDR=0x06 (Set Bus), then WAIT. On OK, set last_bus and bus_valid=1. Otherwise skip directly to START.
- START: CMDR=0x04.
- ADDR: DPR={addr,rw}, then CMDR=0x01.
- DATA:
  - write: DPR=data, then CMDR=0x01.
  - read: CMDR=0x03 (read with NAK).
- STOP: CMDR=0x05.
- READ_DPR (read requests only, after STOP completes): read DPR into rsp_data_o.
- RESP: rsp_valid_o=1 for one cycle, then IDLE.
- WAIT: after every CMDR write, wait for irq_i=1, then read CMDR and decode:
  - bit7 DON → continue.
  - bit6 NAK → status 01.
  - bit5 AL → status 10.
  - bit4 ERR → status 11.
  - Priority when several bits are set: ERR > AL > NAK > DON.
- Timeout: the counter clears on every CMDR write and increments each WAIT cycle. Reaching TIMEOUT_CYCLES gives status 11, issues no STOP, clears bus_valid, then RESP.
- Error routing:
  - NAK during ADDR or write DATA: skip remaining data, issue STOP, then RESP with 01.
  - AL or ERR at any command: no STOP, clear bus_valid, RESP immediately.
  - NAK returned on the STOP or Set Bus command itself is treated as ERR.
- rsp_data_o updates only on successful reads.
- The FSMR register is never accessed.
- irq_i asserted while not in WAIT is ignored.

Test Plan:
- Reset, then write req (bus 0, addr 0x22, data 0xA5), DUT OK at every step.
  - Required Wishbone write sequence: CSR←C0, DPR←00, CMDR←06, CMDR←04, DPR←44, CMDR←01, DPR←A5, CMDR←01, CMDR←05.
  - Each CMDR write followed by a CMDR read.
  - Then rsp_valid_o pulse with status 00.
- Second write req to same bus: no DPR←bus / CMDR←06 accesses.
- Read req addr 0x22, slave returns 0x3C:
  - DPR←45, CMDR←03, STOP, DPR read.
  - Then rsp_data_o=3C, status 00.
- Read request to a different bus: DPR←bus / CMDR←06 accesses are issued again.
- Address NAK (CMDR reads 0xC0 after address write): no data command, STOP issued, status 01.
- irq_i held 0 with TIMEOUT_CYCLES=100: rsp status 11 exactly 100 cycles after the CMDR write ack; next req redoes Set Bus.
- rst_ni low while stb_o high mid-transfer: cyc_o/stb_o low the same timestep, req_ready_o=0; after release, CSR←C0 is reissued before req_ready_o=1.
